instr_word_assembler: RTL and testbench
=======================================

// Module: instr_word_assembler
// PURPOSE
//  Receive-side counterpart of the byte-serialising instruction buffer: collects
//  NB_WORD/NB_DATA consecutive bytes from uart_rx (rx_done_tick/dout) into one
//  instruction word and hands it, with a write address, to the MIPS instruction-
//  memory loader via a valid/ready handshake. A HALT_WORD ends program loading.
// PARAMETERS
//  NB_DATA    8             bits per UART byte
//  NB_WORD    32            instruction width; NB_WORD/NB_DATA bytes per word (4)
//  NB_ADDR    8             word-address width of instruction memory
//  TOUT_CYC   50000         max clk cycles between bytes of one word
//  NB_TOUT    16            counter width, 2^NB_TOUT > TOUT_CYC
//  HALT_WORD  32'hFFFFFFFF  end-of-program marker word
// PORTS
//  clk           in   1        system clock, rising edge
//  reset         in   1        synchronous, active-high
//  rx_done_tick  in   1        one-cycle strobe: din holds a new byte
//  din           in   NB_DATA  received byte
//  i_ready       in   1        loader accepts word this cycle
//  o_word        out  NB_WORD  assembled word, stable while o_valid
//  o_addr        out  NB_ADDR  word address of o_word
//  o_valid       out  1        word available
//  o_done        out  1        HALT_WORD accepted; sticky
//  o_err         out  1        sticky: overrun, timeout or address wrap
// BEHAVIOUR
//  - Reset: state IDLE; o_word=0, o_addr=0, o_valid=0, o_done=0, o_err=0,
//    byte count=0, timeout counter=0. Reset mid-word discards partial data.
//  - Byte order: first byte received is MSB: word = {b0,b1,b2,b3}.
//  - States:
//    IDLE:    rx_done_tick -> shift din in, cnt=1, -> COLLECT.
//    COLLECT: rx_done_tick -> shift in, cnt++, timeout cnt cleared; on last
//             byte (cnt reaches 4) -> PRESENT, o_valid=1 next cycle (latency 1
//             clk after 4th tick). No tick for TOUT_CYC cycles -> drop partial
//             word, o_err=1, -> IDLE.
//    PRESENT: o_valid=1, o_word/o_addr held. o_valid&&i_ready = handshake:
//             o_addr++ ; if o_word==HALT_WORD -> o_done=1, -> DONE, else -> IDLE.
//             rx_done_tick same cycle as handshake -> byte becomes b0 of next
//             word (-> COLLECT, cnt=1). rx_done_tick without handshake ->
//             overrun: byte dropped, o_err=1, stay PRESENT.
//    DONE:    o_valid=0; all bytes ignored; exit only by reset.
//  - Address: o_addr increments modulo 2^NB_ADDR on each handshake; the
//    handshake of address 2^NB_ADDR-1 wraps to 0 and sets o_err.
//  - HALT_WORD is delivered through the handshake like any word (loader
//    stores it), o_done rises the cycle after its handshake.
//  - o_err/o_done never clear except by reset.
// STRUCTURE
//  - Shared package: state encoding (NB_STATE=2: IDLE, COLLECT, PRESENT,
//    DONE), HALT_WORD and bytes-per-word constant, shared with instruc_buffer.
//  - One sub-module: inter-byte timeout counter (byte_timeout_cnt: clear,
//    enable, expire pulse). Shift register, FSM, address counter inline.
// TESTING
//  - Bytes FF,00,FF,00 then i_ready=1 -> o_word=32'hFF00FF00, o_addr=0,
//    o_valid 1 clk after 4th tick; next word gets o_addr=1.
//  - 3 bytes then idle TOUT_CYC+1 cycles -> o_err=1, partial dropped; next
//    4 bytes F0,F0,FF,18 -> o_word=32'hF0F0FF18.
//  - Hold i_ready=0 in PRESENT, send 1 byte -> o_err=1, o_word unchanged;
//    byte coincident with handshake -> counted as b0 of next word.
//  - Send FF,FF,FF,FF, handshake -> o_done=1 next cycle; further bytes
//    ignored, o_valid stays 0.
//  - Reset asserted after 2 bytes -> all outputs 0; next 4 bytes form a clean
//    word at o_addr=0.
//  - With NB_ADDR=2, five handshakes -> o_addr sequence 0,1,2,3,0, o_err=1.

Source files
------------

// File: rtl/instr_word_assembler_pkg.sv
// Shared constants and state encoding for the UART instruction word path.
// Used by both the word assembler and the serialising instruction buffer.
package instr_word_assembler_pkg;

  localparam int NB_STATE = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] HALT_WORD_C = 32'hFFFF_FFFF;

  typedef enum logic [NB_STATE-1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/instr_word_assembler_if.sv
// Byte-in / word-out bundle between uart_rx, the assembler and the
// instruction-memory loader.
interface instr_word_assembler_if #(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 8
);

  logic               rx_done_tick;
  logic [NB_DATA-1:0] din;
  logic               i_ready;
  logic [NB_WORD-1:0] o_word;
  logic [NB_ADDR-1:0] o_addr;
  logic               o_valid;
  logic               o_done;
  logic               o_err;

  modport master (
    output rx_done_tick, din, i_ready,
    input  o_word, o_addr, o_valid,
    input  o_done, o_err
  );

  modport slave (
    input  rx_done_tick, din, i_ready,
    output o_word, o_addr, o_valid,
    output o_done, o_err
  );

endinterface

// File: rtl/instr_word_assembler_tout.sv
// Inter-byte timeout: counts enabled cycles since the last clear and
// pulses expire on the TOUT_CYC-th consecutive enabled cycle.
module byte_timeout_cnt #(
  parameter int TOUT_CYC = 50000,
  parameter int NB_TOUT  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [NB_TOUT-1:0] cnt_q;
  logic [NB_TOUT-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = en_i &&
    (cnt_q == NB_TOUT'(TOUT_CYC - 1));

endmodule

// File: rtl/instr_word_assembler.sv
// Packs MSB-first UART bytes into instruction words and hands them,
// with an incrementing word address, to the instruction-memory loader.
module instr_word_assembler
  import instr_word_assembler_pkg::*;
#(
  parameter int NB_DATA  = 8,
  parameter int NB_WORD  = 32,
  parameter int NB_ADDR  = 8,
  parameter int TOUT_CYC = 50000,
  parameter int NB_TOUT  = 16,
  parameter logic [NB_WORD-1:0] HALT_WORD =
    NB_WORD'(HALT_WORD_C)
) (
  input logic                   clk,
  input logic                   reset,
  instr_word_assembler_if.slave bus
);

  localparam int BPW    = NB_WORD / NB_DATA;
  localparam int NB_CNT = $clog2(BPW) + 1;

  state_e             state_q, state_d;
  logic [NB_WORD-1:0] word_q, word_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               tout_clr;
  logic               tout_en;
  logic               tout_exp;
  logic [NB_WORD-1:0] shifted;

  assign shifted = {word_q[NB_WORD-NB_DATA-1:0], bus.din};

  byte_timeout_cnt #(
    .TOUT_CYC (TOUT_CYC),
    .NB_TOUT  (NB_TOUT)
  ) u_tout (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tout_clr),
    .en_i     (tout_en),
    .expire_o (tout_exp)
  );

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    done_d   = done_q;
    tout_clr = 1'b1;
    tout_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rx_done_tick) begin
          word_d  = shifted;
          cnt_d   = NB_CNT'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        tout_clr = bus.rx_done_tick;
        tout_en  = !bus.rx_done_tick;
        if (bus.rx_done_tick) begin
          word_d = shifted;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == NB_CNT'(BPW - 1))
            state_d = PRESENT;
        end else if (tout_exp) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (bus.i_ready) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = '0;
          if (&addr_q)
            err_d = 1'b1;
          if (word_q == HALT_WORD) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else if (bus.rx_done_tick) begin
            // byte arriving with the handshake opens the next word
            word_d  = shifted;
            cnt_d   = NB_CNT'(1);
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.rx_done_tick) begin
          err_d = 1'b1;
        end
      end
      DONE: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_word  = word_q;
  assign bus.o_addr  = addr_q;
  assign bus.o_valid = (state_q == PRESENT);
  assign bus.o_done  = done_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_instr_word_assembler.sv
// Self-checking bench for instr_word_assembler: table vectors, directed
// corner sequences and a randomized run against a queue-based model.
module tb_instr_word_assembler;

  localparam int NB_ADDR  = 2;
  localparam int TOUT_CYC = 40;
  localparam int NB_TOUT  = 8;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  instr_word_assembler_if #(
    .NB_DATA (8),
    .NB_WORD (32),
    .NB_ADDR (NB_ADDR)
  ) bus ();

  instr_word_assembler #(
    .NB_DATA  (8),
    .NB_WORD  (32),
    .NB_ADDR  (NB_ADDR),
    .TOUT_CYC (TOUT_CYC),
    .NB_TOUT  (NB_TOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] word;
    logic [1:0]  addr;
    logic        err;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_done_tick = 1'b1;
    bus.din          = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic handshake();
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      @(negedge clk);
  endtask

  // behavioural reference for the random run
  logic [7:0]  m_q[$];
  logic [31:0] m_word;
  int          m_addr;
  int          m_idle;
  bit          m_present, m_done, m_err;

  task automatic m_reset();
    m_q.delete();
    m_word = 0; m_addr = 0; m_idle = 0;
    m_present = 0; m_done = 0; m_err = 0;
  endtask

  task automatic m_step(input bit rst, input bit tk,
                        input logic [7:0] d, input bit rdy);
    if (rst) begin
      m_reset();
    end else if (m_done) begin
    end else if (m_present) begin
      if (rdy) begin
        if (m_addr == (1 << NB_ADDR) - 1) m_err = 1;
        m_addr = (m_addr + 1) % (1 << NB_ADDR);
        m_present = 0;
        if (m_word == 32'hFFFF_FFFF) m_done = 1;
        else if (tk) begin
          m_q.push_back(d);
          m_idle = 0;
        end
      end else if (tk) begin
        m_err = 1;
      end
    end else if (tk) begin
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == 4) begin
        m_word = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_q.delete();
        m_present = 1;
      end
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (m_idle == TOUT_CYC) begin
        m_err = 1;
        m_q.delete();
        m_idle = 0;
      end
    end
  endtask

  initial begin
    bit rst_r, tk_r, rdy_r;
    logic [7:0] d_r;
    int gap;

    reset = 1'b1;
    bus.rx_done_tick = 1'b0;
    bus.din = 8'h00;
    bus.i_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_word",  bus.o_word, 32'h0);
    check("rst_addr",  32'(bus.o_addr), 32'h0);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_done",  32'(bus.o_done), 32'h0);
    check("rst_err",   32'(bus.o_err), 32'h0);

    // five words through a 2-bit address: 0,1,2,3 then wrap to 0
    tbl[0] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'hFF00FF00, 2'd0, 1'b0};
    tbl[1] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h12345678, 2'd1, 1'b0};
    tbl[2] = '{8'hA5, 8'hA5, 8'h00, 8'h5A, 32'hA5A5005A, 2'd2, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h00000001, 2'd3, 1'b0};
    tbl[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEADBEEF, 2'd0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      send_byte(tbl[i].b0);
      send_byte(tbl[i].b1);
      send_byte(tbl[i].b2);
      check("tbl_valid_early", 32'(bus.o_valid), 32'h0);
      send_byte(tbl[i].b3);
      check("tbl_valid", 32'(bus.o_valid), 32'h1);
      check("tbl_word", bus.o_word, tbl[i].word);
      check("tbl_addr", 32'(bus.o_addr), 32'(tbl[i].addr));
      check("tbl_err", 32'(bus.o_err), 32'(tbl[i].err));
      handshake();
      check("tbl_valid_after", 32'(bus.o_valid), 32'h0);
    end
    check("wrap_err", 32'(bus.o_err), 32'h1);
    check("wrap_addr", 32'(bus.o_addr), 32'h1);

    // inter-byte timeout
    do_reset();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(TOUT_CYC - 1);
    check("tout_not_yet", 32'(bus.o_err), 32'h0);
    idle(2);
    check("tout_err", 32'(bus.o_err), 32'h1);
    check("tout_valid", 32'(bus.o_valid), 32'h0);
    send_byte(8'hF0); send_byte(8'hF0);
    send_byte(8'hFF); send_byte(8'h18);
    check("tout_next_valid", 32'(bus.o_valid), 32'h1);
    check("tout_next_word", bus.o_word, 32'hF0F0FF18);
    check("tout_next_addr", 32'(bus.o_addr), 32'h0);

    // overrun, then a byte coincident with the handshake
    do_reset();
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h77);
    check("ovr_err", 32'(bus.o_err), 32'h1);
    check("ovr_valid", 32'(bus.o_valid), 32'h1);
    check("ovr_word", bus.o_word, 32'h11223344);
    bus.i_ready = 1'b1;
    send_byte(8'hAB);
    bus.i_ready = 1'b0;
    check("coin_valid", 32'(bus.o_valid), 32'h0);
    check("coin_addr", 32'(bus.o_addr), 32'h1);
    send_byte(8'hCD); send_byte(8'hEF); send_byte(8'h01);
    check("coin_valid2", 32'(bus.o_valid), 32'h1);
    check("coin_word", bus.o_word, 32'hABCDEF01);
    handshake();

    // halt word ends loading
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    check("halt_valid", 32'(bus.o_valid), 32'h1);
    check("halt_done_pre", 32'(bus.o_done), 32'h0);
    check("halt_addr", 32'(bus.o_addr), 32'h2);
    handshake();
    check("halt_done", 32'(bus.o_done), 32'h1);
    check("halt_valid_off", 32'(bus.o_valid), 32'h0);
    check("halt_addr_inc", 32'(bus.o_addr), 32'h3);
    for (int i = 0; i < 5; i++) send_byte(8'h5A);
    check("done_valid", 32'(bus.o_valid), 32'h0);
    check("done_sticky", 32'(bus.o_done), 32'h1);

    // reset mid-word discards partial bytes
    send_byte(8'h99);
    do_reset();
    send_byte(8'h98); send_byte(8'h97);
    do_reset();
    check("mid_word", bus.o_word, 32'h0);
    check("mid_addr", 32'(bus.o_addr), 32'h0);
    check("mid_done", 32'(bus.o_done), 32'h0);
    check("mid_err", 32'(bus.o_err), 32'h0);
    check("mid_valid", 32'(bus.o_valid), 32'h0);
    send_byte(8'hC0); send_byte(8'hDE);
    send_byte(8'h00); send_byte(8'h42);
    check("mid_clean_word", bus.o_word, 32'hC0DE0042);
    check("mid_clean_addr", 32'(bus.o_addr), 32'h0);
    check("mid_clean_valid", 32'(bus.o_valid), 32'h1);

    // randomized run against the model
    do_reset();
    m_reset();
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_r = ($urandom_range(0, 399) == 0);
      if (gap > 0) begin
        tk_r = 0;
        gap--;
      end else if ($urandom_range(0, 59) == 0) begin
        tk_r = 0;
        gap = TOUT_CYC + $urandom_range(-3, 5);
      end else begin
        tk_r = ($urandom_range(0, 2) == 0);
      end
      d_r = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      rdy_r = ($urandom_range(0, 1) == 0);
      reset = rst_r;
      bus.rx_done_tick = tk_r;
      bus.din = d_r;
      bus.i_ready = rdy_r;
      @(posedge clk);
      m_step(rst_r, tk_r, d_r, rdy_r);
      @(negedge clk);
      check("rnd_valid", 32'(bus.o_valid), 32'(m_present));
      check("rnd_addr", 32'(bus.o_addr), 32'(m_addr));
      check("rnd_done", 32'(bus.o_done), 32'(m_done));
      check("rnd_err", 32'(bus.o_err), 32'(m_err));
      if (m_present)
        check("rnd_word", bus.o_word, m_word);
    end
    reset = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.i_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
